// File: rtl/ocx_dlx_rx_retrain_seq_pkg.sv
`default_nettype none
//============================================================================
// Module   : ocx_dlx_rx_retrain_seq_pkg
// Purpose  : Shared state encoding and lane-sync helper for the RX-datapath
//            retrain sequencer.
// Revision : 1.0  initial release
//============================================================================
package ocx_dlx_rx_retrain_seq_pkg;

    localparam int unsigned LANES = 8;

    // Encodings are visible on the seq_state debug port, so they are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SYNC = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_LINKED    = 3'd4,
        ST_ERROR     = 3'd5
    } seq_state_e;

    // All enabled lanes report sync; an empty mask never counts as synced.
    function automatic logic lanes_synced(input logic [LANES-1:0] run,
                                          input logic [LANES-1:0] mask);
        return (mask != '0) && ((run | ~mask) == {LANES{1'b1}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocx_dlx_retrain_timer.sv
`default_nettype none
//============================================================================
// Module   : ocx_dlx_retrain_timer
// Purpose  : Saturating up-counter with synchronous clear and a terminal-count
//            compare against a run-time value.
// Ports    : clk, rst_n (async, active-low), clear_i, enable_i,
//            tc_val_i [W]  terminal-count value
//            count_o  [W]  current count
//            tc_o          count_o == tc_val_i
// Revision : 1.0  initial release
//============================================================================
module ocx_dlx_retrain_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;

    // Holds at all-ones instead of wrapping so a long stay never re-arms tc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == tc_val_i);

endmodule
`default_nettype wire

// File: rtl/ocx_dlx_rx_retrain_seq.sv
`default_nettype none
//============================================================================
// Module   : ocx_dlx_rx_retrain_seq
// Purpose  : Sequences the transceiver RX-datapath retrain on the RX clock:
//            waits for lane sync, pulses the RX datapath reset, waits for the
//            RX reset / buffer-bypass done flags with timeout, retries and
//            flags an error once retries are exhausted.
// Ports    : opt_gckn clock, ocde async active-low reset,
//            pb_io_o0_rx_run_lane[8] / lane_mask[8] lane sync and enables,
//            retrain_req pulse, gtwiz_* done/active status inputs,
//            gtwiz_reset_rx_datapath_out, io_pb_o0_rx_init_done[8],
//            retrain_err, retry_cnt[RETRY_W], seq_state[3] (debug).
// Revision : 1.0  initial release
//============================================================================
module ocx_dlx_rx_retrain_seq
    import ocx_dlx_rx_retrain_seq_pkg::*;
#(
    parameter int unsigned PULSE_CYC    = 8,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned DONE_TIMEOUT = 4096,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RETRY_W      = $clog2(MAX_RETRY + 1)
) (
    input  logic               opt_gckn,
    input  logic               ocde,
    input  logic [7:0]         pb_io_o0_rx_run_lane,
    input  logic [7:0]         lane_mask,
    input  logic               retrain_req,
    input  logic               gtwiz_reset_tx_done_in,
    input  logic               gtwiz_buffbypass_tx_done_in,
    input  logic               gtwiz_reset_rx_done_in,
    input  logic               gtwiz_buffbypass_rx_done_in,
    input  logic               gtwiz_userclk_rx_active_in,
    output logic               gtwiz_reset_rx_datapath_out,
    output logic [7:0]         io_pb_o0_rx_init_done,
    output logic               retrain_err,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         seq_state
);

    localparam int unsigned     TMR_W    = $clog2(DONE_TIMEOUT);
    localparam logic [TMR_W-1:0] PULSE_TC = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] DONE_TC  = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] BLANK_V  = TMR_W'(BLANK_CYC);

    seq_state_e         state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               dp_q;
    logic               err_q;
    logic [7:0]         init_q;

    logic               w_tx_ok;
    logic               w_rx_ok;
    logic               w_sync_all;
    logic [TMR_W-1:0]   w_tmr;
    logic [TMR_W-1:0]   w_tc_val;
    logic               w_tmr_tc;
    logic               w_tmr_clear;

    assign w_tx_ok    = gtwiz_reset_tx_done_in & gtwiz_buffbypass_tx_done_in;
    assign w_rx_ok    = gtwiz_reset_rx_done_in & gtwiz_buffbypass_rx_done_in
                      & gtwiz_userclk_rx_active_in;
    assign w_sync_all = lanes_synced(pb_io_o0_rx_run_lane, lane_mask);

    // One timer serves both HOLD (pulse width) and WAIT_DONE (timeout); it
    // restarts from zero on every state change.
    assign w_tc_val    = (state_q == ST_HOLD) ? PULSE_TC : DONE_TC;
    assign w_tmr_clear = (state_d != state_q);

    ocx_dlx_retrain_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (opt_gckn),
        .rst_n    (ocde),
        .clear_i  (w_tmr_clear),
        .enable_i (1'b1),
        .tc_val_i (w_tc_val),
        .count_o  (w_tmr),
        .tc_o     (w_tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if ((state_q != ST_IDLE) && !w_tx_ok) begin
            // Losing TX readiness aborts everything, including a retrain_req.
            state_d = ST_IDLE;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_tx_ok) begin
                        state_d = ST_WAIT_SYNC;
                        retry_d = '0;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (w_sync_all) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_tmr_tc) state_d = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (retrain_req) begin
                        state_d = ST_HOLD;
                    end else if (w_rx_ok && (w_tmr >= BLANK_V)) begin
                        // Done flags seen during blanking may be stale.
                        state_d = ST_LINKED;
                    end else if (w_tmr_tc) begin
                        if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_LINKED: begin
                    if (retrain_req) begin
                        state_d = ST_HOLD;
                        retry_d = '0;
                    end else if (!w_rx_ok) begin
                        state_d = ST_WAIT_SYNC;
                    end
                end
                ST_ERROR: begin
                    if (retrain_req) begin
                        state_d = ST_WAIT_SYNC;
                        retry_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are derived from the next state so they line up with seq_state.
    always_ff @(posedge opt_gckn or negedge ocde) begin
        if (!ocde) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            dp_q    <= 1'b0;
            err_q   <= 1'b0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            dp_q    <= (state_d == ST_HOLD);
            err_q   <= (state_d == ST_ERROR);
            init_q  <= ((state_q == ST_LINKED) && (state_d == ST_LINKED))
                     ? (lane_mask & {8{w_rx_ok}}) : 8'h00;
        end
    end

    assign gtwiz_reset_rx_datapath_out = dp_q;
    assign io_pb_o0_rx_init_done       = init_q;
    assign retrain_err                 = err_q;
    assign retry_cnt                   = retry_q;
    assign seq_state                   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ocx_dlx_rx_retrain_seq.sv
`default_nettype none
//============================================================================
// Module   : tb_ocx_dlx_rx_retrain_seq
// Purpose  : Self-checking bench for the RX retrain sequencer: a behavioural
//            model compared every cycle plus directed literal checks.
// Revision : 1.0  initial release
//============================================================================
module tb_ocx_dlx_rx_retrain_seq;

    localparam int PULSE   = 8;
    localparam int BLANK   = 16;
    localparam int TIMEOUT = 4096;
    localparam int MAXR    = 3;

    localparam int M_IDLE = 0, M_WS = 1, M_HOLD = 2, M_WD = 3, M_LNK = 4, M_ERR = 5;

    logic       clk = 1'b0;
    logic       ocde = 1'b1;
    logic [7:0] run_lane = 8'h00;
    logic [7:0] lane_mask = 8'h00;
    logic       retrain_req = 1'b0;
    logic       rst_tx_done = 1'b0;
    logic       bb_tx_done = 1'b0;
    logic       rst_rx_done = 1'b0;
    logic       bb_rx_done = 1'b0;
    logic       uclk_active = 1'b0;

    logic       dp_out;
    logic [7:0] init_done;
    logic       err;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int n_pass = 0;
    int n_total = 0;

    ocx_dlx_rx_retrain_seq dut (
        .opt_gckn                    (clk),
        .ocde                        (ocde),
        .pb_io_o0_rx_run_lane        (run_lane),
        .lane_mask                   (lane_mask),
        .retrain_req                 (retrain_req),
        .gtwiz_reset_tx_done_in      (rst_tx_done),
        .gtwiz_buffbypass_tx_done_in (bb_tx_done),
        .gtwiz_reset_rx_done_in      (rst_rx_done),
        .gtwiz_buffbypass_rx_done_in (bb_rx_done),
        .gtwiz_userclk_rx_active_in  (uclk_active),
        .gtwiz_reset_rx_datapath_out (dp_out),
        .io_pb_o0_rx_init_done       (init_done),
        .retrain_err                 (err),
        .retry_cnt                   (retry_cnt),
        .seq_state                   (seq_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    endtask

    // ---------------- behavioural model ----------------
    int       m_st = M_IDLE;
    int       m_tmr = 0;      // cycles spent in the current state
    int       m_retry = 0;
    int       m_init = 0;
    int       n_st, n_r;
    bit       tx, rx, any_lane, all_run;

    always @(posedge clk or negedge ocde) begin
        if (!ocde) begin
            m_st <= M_IDLE; m_tmr <= 0; m_retry <= 0; m_init <= 0;
        end else begin
            tx = rst_tx_done && bb_tx_done;
            rx = rst_rx_done && bb_rx_done && uclk_active;
            any_lane = 0; all_run = 1;
            for (int l = 0; l < 8; l++) begin
                if (lane_mask[l]) begin
                    any_lane = 1;
                    if (!run_lane[l]) all_run = 0;
                end
            end
            n_st = m_st; n_r = m_retry;
            if (m_st == M_IDLE) begin
                if (tx) begin n_st = M_WS; n_r = 0; end
            end else if (!tx) begin
                n_st = M_IDLE; n_r = 0;
            end else begin
                case (m_st)
                    M_WS:   if (any_lane && all_run) n_st = M_HOLD;
                    M_HOLD: if (m_tmr + 1 == PULSE) n_st = M_WD;
                    M_WD: begin
                        if (retrain_req) n_st = M_HOLD;
                        else if (rx && m_tmr >= BLANK) n_st = M_LNK;
                        else if (m_tmr + 1 == TIMEOUT) begin
                            if (m_retry < MAXR) begin n_r = m_retry + 1; n_st = M_HOLD; end
                            else n_st = M_ERR;
                        end
                    end
                    M_LNK: begin
                        if (retrain_req) begin n_st = M_HOLD; n_r = 0; end
                        else if (!rx) n_st = M_WS;
                    end
                    M_ERR: if (retrain_req) begin n_st = M_WS; n_r = 0; end
                    default: n_st = M_IDLE;
                endcase
            end
            m_init  <= (m_st == M_LNK && n_st == M_LNK) ? int'(lane_mask) : 0;
            m_tmr   <= (n_st != m_st) ? 0 : ((m_tmr < TIMEOUT - 1) ? m_tmr + 1 : m_tmr);
            m_st    <= n_st;
            m_retry <= n_r;
        end
    end

    always @(negedge clk) begin
        chk("m_state", 32'(seq_state), m_st);
        chk("m_dp",    32'(dp_out), (m_st == M_HOLD) ? 1 : 0);
        chk("m_err",   32'(err), (m_st == M_ERR) ? 1 : 0);
        chk("m_retry", 32'(retry_cnt), m_retry);
        chk("m_init",  32'(init_done), m_init);
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_state(input int s, input int lim, input string nm);
        int n = 0;
        while (seq_state != 3'(s) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(seq_state), s);
    endtask

    task automatic pulse_req();
        retrain_req = 1'b1;
        @(negedge clk);
        retrain_req = 1'b0;
    endtask

    initial begin
        int cnt;
        #1 ocde = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(seq_state), 0);
        chk("rst_dp", 32'(dp_out), 0);
        chk("rst_init", 32'(init_done), 0);
        chk("rst_err", 32'(err), 0);

        // T1: pulse width
        rst_tx_done = 1; bb_tx_done = 1; lane_mask = 8'hFF; run_lane = 8'hFF;
        ocde = 1'b1;
        wait_state(M_HOLD, 10, "t1_hold");
        cnt = 0;
        while (dp_out && cnt < 50) begin cnt++; @(negedge clk); end
        chk("t1_pulse_len", cnt, 8);
        chk("t1_wait_done", 32'(seq_state), M_WD);

        // T2: rx_ok through pulse, blanking then LINKED
        rst_rx_done = 1; bb_rx_done = 1; uclk_active = 1;
        pulse_req();
        chk("t2_hold", 32'(seq_state), M_HOLD);
        chk("t2_retry", 32'(retry_cnt), 0);
        wait_state(M_WD, 20, "t2_wd");
        cnt = 0;
        while (seq_state == 3'(M_WD) && cnt < 100) begin cnt++; @(negedge clk); end
        chk("t2_blank", cnt, 17);
        chk("t2_linked", 32'(seq_state), M_LNK);
        chk("t2_init_lat", 32'(init_done), 0);
        @(negedge clk);
        chk("t2_init", 32'(init_done), 32'hFF);

        // T5: tx drop beats retrain_req
        rst_tx_done = 0;
        pulse_req();
        chk("t5_idle", 32'(seq_state), M_IDLE);
        chk("t5_init", 32'(init_done), 0);
        @(negedge clk);
        chk("t5_stay", 32'(seq_state), M_IDLE);

        // T3: partial lane mask
        lane_mask = 8'h0F; run_lane = 8'h07; rst_tx_done = 1;
        repeat (20) @(negedge clk);
        chk("t3_stuck", 32'(seq_state), M_WS);
        rst_rx_done = 0;
        run_lane = 8'h0F;
        wait_state(M_HOLD, 5, "t3_hold");

        // T4: retries then ERROR
        for (int i = 1; i <= 3; i++) begin
            wait_state(M_WD, 20, "t4_wd");
            wait_state(M_HOLD, 4200, "t4_retry_hold");
            chk("t4_retry", 32'(retry_cnt), i);
        end
        wait_state(M_WD, 20, "t4_wd_last");
        wait_state(M_ERR, 4200, "t4_error");
        chk("t4_err", 32'(err), 1);
        chk("t4_err_retry", 32'(retry_cnt), 3);
        chk("t4_err_dp", 32'(dp_out), 0);
        pulse_req();
        chk("t4_rearm", 32'(seq_state), M_WS);
        chk("t4_rearm_err", 32'(err), 0);
        chk("t4_rearm_retry", 32'(retry_cnt), 0);

        // T6: rx_ok arrives on the timeout cycle
        wait_state(M_HOLD, 5, "t6_hold");
        wait_state(M_WD, 20, "t6_wd");
        repeat (4095) @(negedge clk);
        chk("t6_before", 32'(seq_state), M_WD);
        rst_rx_done = 1;
        @(negedge clk);
        chk("t6_linked", 32'(seq_state), M_LNK);
        chk("t6_retry", 32'(retry_cnt), 0);

        // T6: async reset mid-HOLD
        pulse_req();
        chk("t6_hold2", 32'(seq_state), M_HOLD);
        @(negedge clk);
        #2 ocde = 1'b0;
        #1;
        chk("t6_async_dp", 32'(dp_out), 0);
        chk("t6_async_state", 32'(seq_state), M_IDLE);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
